// File: rtl/avalon_width_adapter_pkg.sv
// Shared definitions for the Avalon-MM width-down adapter.
//   state_e     : issue FSM states
//   clog2       : ceiling log2 usable in parameter expressions
//   beat_bytes  : bytes carried by one narrow beat
//   cnt_w       : width of a counter that indexes RATIO beats/slices
// DEF_* localparams are the values for the default build (RATIO=4, 64-bit beats).
package avl_adapt_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WR_BEATS = 2'd1,
        RD_BEATS = 2'd2
    } state_e;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'sd1 <<< i) < value) r = i + 1;
        end
        return r;
    endfunction

    function automatic int beat_bytes(input int data_width_m);
        return data_width_m / 8;
    endfunction

    function automatic int cnt_w(input int ratio);
        return clog2(ratio);
    endfunction

    localparam int DEF_RATIO      = 4;
    localparam int DEF_BEAT_BYTES = beat_bytes(64);
    localparam int DEF_CNT_W      = cnt_w(DEF_RATIO);

endpackage

// File: rtl/avalon_width_adapter_rd_gather.sv
// Read-response gather for the width-down adapter.
// Collects RATIO in-order narrow read beats into one wide word and pulses
// s_rdata_valid for one cycle on the edge after the last slice arrives.
// Also tracks how many wide reads are outstanding.
// Ports:
//   clk, reset        clock, async active-high reset
//   rd_accept         a wide read was accepted this edge
//   m_rdata_valid/_rdata  narrow response beat from the master side
//   s_rdata_valid/_rdata  gathered wide response (registered)
//   pend_full         outstanding reads have reached MAX_PENDING
module avl_rd_gather
    import avl_adapt_pkg::*;
#(
    parameter int DATA_WIDTH_M = 64,
    parameter int RATIO        = 4,
    parameter int MAX_PENDING  = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          rd_accept,
    input  logic                          m_rdata_valid,
    input  logic [DATA_WIDTH_M-1:0]       m_rdata,
    output logic                          s_rdata_valid,
    output logic [RATIO*DATA_WIDTH_M-1:0] s_rdata,
    output logic                          pend_full
);

    localparam int DW_S   = RATIO * DATA_WIDTH_M;
    localparam int CNT_W  = cnt_w(RATIO);
    localparam int PEND_W = clog2(MAX_PENDING + 1);
    localparam logic [CNT_W-1:0] LAST_SLICE = CNT_W'(RATIO - 1);

    logic [CNT_W-1:0]  gcnt_q, gcnt_d;
    logic [PEND_W-1:0] pend_q, pend_d;
    logic [DW_S-1:0]   buf_q, buf_d;
    logic [DW_S-1:0]   word_q, word_d;
    logic              valid_q, valid_d;
    logic              take;

    always_comb begin
        // A beat with nothing outstanding and no partial word is a stray
        // (e.g. a late response to a read abandoned by reset).
        take    = m_rdata_valid && !((pend_q == '0) && (gcnt_q == '0));
        buf_d   = buf_q;
        gcnt_d  = gcnt_q;
        word_d  = word_q;
        valid_d = 1'b0;
        if (take) begin
            buf_d[gcnt_q*DATA_WIDTH_M +: DATA_WIDTH_M] = m_rdata;
            if (gcnt_q == LAST_SLICE) begin
                gcnt_d  = '0;
                valid_d = 1'b1;
                word_d  = buf_d;
            end else begin
                gcnt_d = gcnt_q + 1'b1;
            end
        end

        pend_d = pend_q;
        case ({rd_accept, valid_q})
            2'b10:   pend_d = pend_q + 1'b1;
            2'b01:   pend_d = pend_q - 1'b1;
            default: pend_d = pend_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            gcnt_q  <= '0;
            pend_q  <= '0;
            buf_q   <= '0;
            word_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            gcnt_q  <= gcnt_d;
            pend_q  <= pend_d;
            buf_q   <= buf_d;
            word_q  <= word_d;
            valid_q <= valid_d;
        end
    end

    assign s_rdata_valid = valid_q;
    assign s_rdata       = word_q;
    assign pend_full     = (pend_q >= PEND_W'(MAX_PENDING));

endmodule

// File: rtl/avalon_width_adapter.sv
// Avalon-MM width-down adapter: a wide slave port (accelerator side) is
// split into RATIO sequential narrow beats on the master port; narrow read
// responses are gathered back into one wide response by avl_rd_gather.
// Ports:
//   clk, reset                 clock, async active-high reset
//   avl_slave_*                wide command port (ready = waitrequest_n)
//   avl_slave_rdata_valid/_rdata  gathered wide read response
//   avl_master_*               narrow beat port, all outputs registered
// Build option:
//   AVL_ADAPT_SKIP_EMPTY_EN    when defined, write beats whose byteenable
//                              slice is zero are not issued.
//
// state    | meaning
// IDLE     | no command in flight; slave port may accept
// WR_BEATS | presenting write beat beat_q on the master port
// RD_BEATS | presenting read beat beat_q on the master port
module avalon_width_adapter
    import avl_adapt_pkg::*;
#(
    parameter int ADDR_WIDTH   = 64,
    parameter int DATA_WIDTH_M = 64,
    parameter int RATIO        = 4,
    parameter int MAX_PENDING  = 4
) (
    input  logic                              clk,
    input  logic                              reset,
    output logic                              avl_slave_ready,
    input  logic [ADDR_WIDTH-1:0]             avl_slave_addr,
    input  logic [RATIO*DATA_WIDTH_M-1:0]     avl_slave_wdata,
    input  logic [RATIO*DATA_WIDTH_M/8-1:0]   avl_slave_be,
    input  logic                              avl_slave_read_req,
    input  logic                              avl_slave_write_req,
    output logic                              avl_slave_rdata_valid,
    output logic [RATIO*DATA_WIDTH_M-1:0]     avl_slave_rdata,
    input  logic                              avl_master_ready,
    output logic [ADDR_WIDTH-1:0]             avl_master_addr,
    output logic [DATA_WIDTH_M-1:0]           avl_master_wdata,
    output logic [DATA_WIDTH_M/8-1:0]         avl_master_be,
    output logic                              avl_master_read_req,
    output logic                              avl_master_write_req,
    input  logic                              avl_master_rdata_valid,
    input  logic [DATA_WIDTH_M-1:0]           avl_master_rdata
);

    localparam int DW_S  = RATIO * DATA_WIDTH_M;
    localparam int BE_M  = beat_bytes(DATA_WIDTH_M);
    localparam int BE_S  = DW_S / 8;
    localparam int CNT_W = cnt_w(RATIO);
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(BE_S - 1);

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   base_q, base_d;
    logic [DW_S-1:0]         wdata_q, wdata_d;
    logic [BE_S-1:0]         be_q, be_d;
    logic [CNT_W-1:0]        beat_q, beat_d;
    logic [ADDR_WIDTH-1:0]   m_addr_q, m_addr_d;
    logic [DATA_WIDTH_M-1:0] m_wdata_q, m_wdata_d;
    logic [BE_M-1:0]         m_be_q, m_be_d;
    logic                    m_rd_q, m_rd_d;
    logic                    m_wr_q, m_wr_d;

    logic                    pend_full;
    logic                    slave_ready;
    logic                    accept_wr, accept_rd, accept_any;
    logic                    beat_done;
    logic                    skip_en;
    logic                    is_wr;
    int                      start;
    logic [ADDR_WIDTH-1:0]   src_base;
    logic [DW_S-1:0]         src_wdata;
    logic [BE_S-1:0]         src_be;
    logic                    nxt_found;
    logic [CNT_W-1:0]        nxt_idx;

    always_comb begin
        slave_ready = (state_q == IDLE) && !pend_full;
        // Write wins when both requests are raised.
        accept_wr   = slave_ready && avl_slave_write_req;
        accept_rd   = slave_ready && avl_slave_read_req && !avl_slave_write_req;
        accept_any  = accept_wr || accept_rd;
        beat_done   = (m_rd_q || m_wr_q) && avl_master_ready;
    end

`ifdef AVL_ADAPT_SKIP_EMPTY_EN
    assign skip_en = 1'b1;
`else
    assign skip_en = 1'b0;
`endif

    // Next beat to present: on accept the slices come straight from the
    // slave inputs so beat 0 is on the bus the cycle after accept.
    always_comb begin
        src_base  = accept_any ? (avl_slave_addr & ALIGN_MASK) : base_q;
        src_wdata = accept_any ? avl_slave_wdata : wdata_q;
        src_be    = accept_any ? avl_slave_be : be_q;
        is_wr     = accept_any ? accept_wr : (state_q == WR_BEATS);
        start     = accept_any ? 0 : int'(beat_q) + 1;
        nxt_found = 1'b0;
        nxt_idx   = '0;
        // Descending scan so the lowest eligible slice wins.
        for (int i = RATIO - 1; i >= 0; i--) begin
            if (i >= start) begin
                if (!skip_en || !is_wr || (src_be[i*BE_M +: BE_M] != '0)) begin
                    nxt_found = 1'b1;
                    nxt_idx   = CNT_W'(i);
                end
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        base_d    = base_q;
        wdata_d   = wdata_q;
        be_d      = be_q;
        beat_d    = beat_q;
        m_addr_d  = m_addr_q;
        m_wdata_d = m_wdata_q;
        m_be_d    = m_be_q;
        m_rd_d    = m_rd_q;
        m_wr_d    = m_wr_q;

        if (accept_any) begin
            base_d  = src_base;
            wdata_d = avl_slave_wdata;
            be_d    = avl_slave_be;
        end

        // accept_any only in IDLE, beat_done only while a beat is presented.
        if (accept_any || beat_done) begin
            if (nxt_found) begin
                state_d   = is_wr ? WR_BEATS : RD_BEATS;
                beat_d    = nxt_idx;
                m_addr_d  = src_base + ADDR_WIDTH'(int'(nxt_idx) * BE_M);
                m_wdata_d = src_wdata[nxt_idx*DATA_WIDTH_M +: DATA_WIDTH_M];
                m_be_d    = src_be[nxt_idx*BE_M +: BE_M];
                m_wr_d    = is_wr;
                m_rd_d    = !is_wr;
            end else begin
                state_d = IDLE;
                beat_d  = '0;
                m_wr_d  = 1'b0;
                m_rd_d  = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            base_q    <= '0;
            wdata_q   <= '0;
            be_q      <= '0;
            beat_q    <= '0;
            m_addr_q  <= '0;
            m_wdata_q <= '0;
            m_be_q    <= '0;
            m_rd_q    <= 1'b0;
            m_wr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            base_q    <= base_d;
            wdata_q   <= wdata_d;
            be_q      <= be_d;
            beat_q    <= beat_d;
            m_addr_q  <= m_addr_d;
            m_wdata_q <= m_wdata_d;
            m_be_q    <= m_be_d;
            m_rd_q    <= m_rd_d;
            m_wr_q    <= m_wr_d;
        end
    end

    avl_rd_gather #(
        .DATA_WIDTH_M (DATA_WIDTH_M),
        .RATIO        (RATIO),
        .MAX_PENDING  (MAX_PENDING)
    ) u_rd_gather (
        .clk           (clk),
        .reset         (reset),
        .rd_accept     (accept_rd),
        .m_rdata_valid (avl_master_rdata_valid),
        .m_rdata       (avl_master_rdata),
        .s_rdata_valid (avl_slave_rdata_valid),
        .s_rdata       (avl_slave_rdata),
        .pend_full     (pend_full)
    );

    assign avl_slave_ready      = slave_ready;
    assign avl_master_addr      = m_addr_q;
    assign avl_master_wdata     = m_wdata_q;
    assign avl_master_be        = m_be_q;
    assign avl_master_read_req  = m_rd_q;
    assign avl_master_write_req = m_wr_q;

endmodule

// File: tb/tb_avalon_width_adapter.sv
module tb_avalon_width_adapter;

    logic         clk = 1'b0;
    logic         reset;
    logic         s_ready;
    logic [63:0]  s_addr;
    logic [255:0] s_wdata;
    logic [31:0]  s_be;
    logic         s_rd, s_wr;
    logic         s_valid;
    logic [255:0] s_rdata;
    logic         m_ready;
    logic [63:0]  m_addr;
    logic [63:0]  m_wdata;
    logic [7:0]   m_be;
    logic         m_rd, m_wr;
    logic         m_rvalid;
    logic [63:0]  m_rdata;

    logic         auto_valid, man_valid;
    logic [63:0]  auto_data, man_data;
    assign m_rvalid = auto_valid | man_valid;
    assign m_rdata  = man_valid ? man_data : auto_data;

    avalon_width_adapter dut (
        .clk                    (clk),
        .reset                  (reset),
        .avl_slave_ready        (s_ready),
        .avl_slave_addr         (s_addr),
        .avl_slave_wdata        (s_wdata),
        .avl_slave_be           (s_be),
        .avl_slave_read_req     (s_rd),
        .avl_slave_write_req    (s_wr),
        .avl_slave_rdata_valid  (s_valid),
        .avl_slave_rdata        (s_rdata),
        .avl_master_ready       (m_ready),
        .avl_master_addr        (m_addr),
        .avl_master_wdata       (m_wdata),
        .avl_master_be          (m_be),
        .avl_master_read_req    (m_rd),
        .avl_master_write_req   (m_wr),
        .avl_master_rdata_valid (m_rvalid),
        .avl_master_rdata       (m_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [7:0]  be;
        logic        wr;
    } beat_t;

    typedef struct {
        logic [63:0] data;
        int          due;
    } resp_t;

    beat_t        exp_beats[$];
    logic [255:0] exp_wide[$];
    resp_t        resp_q[$];

    int  n_cmp = 0;
    int  n_bad = 0;
    int  cycle = 0;
    int  n_pulses = 0;
    int  first_valid_cyc = -1;
    bit  auto_resp = 1'b0;
    int  resp_delay = 2;

    localparam logic [255:0] WD1 = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                                    64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
    localparam logic [255:0] WD2 = {64'hDDDD_0000_0000_0004, 64'hCCCC_0000_0000_0003,
                                    64'hBBBB_0000_0000_0002, 64'hAAAA_0000_0000_0001};

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] mem_f(input logic [63:0] a);
        return {a[31:0] ^ 32'hA5A5_0000, ~a[31:0]};
    endfunction

    always @(posedge clk) cycle <= cycle + 1;

    // Narrow-side responder: returns queued read data in order after its due cycle.
    initial begin
        auto_valid = 1'b0;
        auto_data  = '0;
        forever begin
            @(posedge clk);
            #1;
            if (resp_q.size() > 0 && resp_q[0].due <= cycle) begin
                auto_valid = 1'b1;
                auto_data  = resp_q[0].data;
                void'(resp_q.pop_front());
            end else begin
                auto_valid = 1'b0;
            end
        end
    end

    // Monitor: checks every completed narrow beat, stall stability and wide responses.
    logic [137:0] held;
    bit           stalled_prev = 1'b0;
    initial begin
        forever begin
            @(negedge clk);
            if (m_rd || m_wr) begin
                if (stalled_prev)
                    check("stall_hold", {m_addr, m_wdata, m_be, m_rd, m_wr}, held);
                if (!m_ready) begin
                    held = {m_addr, m_wdata, m_be, m_rd, m_wr};
                    stalled_prev = 1'b1;
                end else begin
                    stalled_prev = 1'b0;
                    if (exp_beats.size() == 0) begin
                        check("unexpected_beat", {m_addr, m_rd, m_wr}, '0);
                    end else begin
                        beat_t t;
                        t = exp_beats.pop_front();
                        check("beat", {m_addr, m_wr ? m_wdata : 64'h0, m_wr ? m_be : 8'h0, m_wr},
                              {t.addr, t.wr ? t.wdata : 64'h0, t.wr ? t.be : 8'h0, t.wr});
                    end
                    if (m_rd && auto_resp) begin
                        resp_t r;
                        r.data = mem_f(m_addr);
                        r.due  = cycle + resp_delay;
                        resp_q.push_back(r);
                    end
                end
            end else begin
                stalled_prev = 1'b0;
            end
            if (s_valid) begin
                n_pulses++;
                if (first_valid_cyc < 0) first_valid_cyc = cycle;
                if (exp_wide.size() == 0) check("unexpected_rdata", s_rdata, '0);
                else check("wide_rdata", s_rdata, exp_wide.pop_front());
            end
        end
    end

    task automatic push_write(input logic [63:0] addr, input logic [255:0] wd, input logic [31:0] be);
        logic [63:0] b;
        b = addr & ~64'h1F;
        for (int k = 0; k < 4; k++) begin
            beat_t t;
            t.addr  = b + 64'(k * 8);
            t.wdata = wd[k*64 +: 64];
            t.be    = be[k*8 +: 8];
            t.wr    = 1'b1;
`ifdef AVL_ADAPT_SKIP_EMPTY_EN
            if (t.be == 8'h00) continue;
`endif
            exp_beats.push_back(t);
        end
    endtask

    task automatic push_read(input logic [63:0] addr, input bit with_wide);
        logic [63:0] b;
        b = addr & ~64'h1F;
        for (int k = 0; k < 4; k++) begin
            beat_t t;
            t.addr  = b + 64'(k * 8);
            t.wdata = '0;
            t.be    = '0;
            t.wr    = 1'b0;
            exp_beats.push_back(t);
        end
        if (with_wide)
            exp_wide.push_back({mem_f(b + 64'd24), mem_f(b + 64'd16), mem_f(b + 64'd8), mem_f(b)});
    endtask

    // Presents a command and returns the cycle in which it was seen accepted.
    task automatic issue(input bit wr, input logic [63:0] addr, input logic [255:0] wd,
                         input logic [31:0] be, output int acc);
        int n;
        @(posedge clk);
        #1;
        s_addr = addr; s_wdata = wd; s_be = be; s_wr = wr; s_rd = !wr;
        n = 0;
        @(negedge clk);
        while (!s_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!s_ready) check("accept_timeout", 1'b0, 1'b1);
        acc = cycle;
        @(posedge clk);
        #1;
        s_rd = 1'b0; s_wr = 1'b0;
    endtask

    task automatic wait_ready(output int rc);
        int n;
        n = 0;
        @(negedge clk);
        while (!s_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!s_ready) check("ready_timeout", 1'b0, 1'b1);
        rc = cycle;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc, rc, acc5, p0;
        reset = 1'b1;
        s_addr = '0; s_wdata = '0; s_be = '0; s_rd = 1'b0; s_wr = 1'b0;
        m_ready = 1'b1;
        man_valid = 1'b0; man_data = '0;

        repeat (3) @(negedge clk);
        check("reset_req", {m_rd, m_wr, s_valid}, 3'b000);
        check("reset_addr", m_addr, 64'h0);
        check("reset_wdata_be", {m_wdata, m_be}, 72'h0);
        check("reset_rdata", s_rdata, 256'h0);
        @(posedge clk); #1; reset = 1'b0;
        @(negedge clk);
        check("ready_after_reset", s_ready, 1'b1);

        // Full write, no backpressure
        push_write(64'h1000, WD1, 32'hFFFF_FFFF);
        issue(1'b1, 64'h1000, WD1, 32'hFFFF_FFFF, acc);
        wait_ready(rc);
        check("wr_accept_to_ready", rc - acc, 5);

        // Backpressure on beat 2
        push_write(64'h1100, WD2, 32'hFFFF_FFFF);
        issue(1'b1, 64'h1100, WD2, 32'hFFFF_FFFF, acc);
        @(posedge clk); #1;
        @(posedge clk); #1;
        m_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_ready_low", s_ready, 1'b0);
            @(posedge clk); #1;
        end
        m_ready = 1'b1;
        wait_ready(rc);
        check("bp_accept_to_ready", rc - acc, 8);

        // Pipelined reads up to MAX_PENDING
        auto_resp = 1'b1;
        resp_delay = 20;
        first_valid_cyc = -1;
        for (int i = 0; i < 4; i++) begin
            push_read(64'h2000 + 64'(i * 32), 1'b1);
            issue(1'b0, 64'h2000 + 64'(i * 32), '0, 32'hFFFF_FFFF, acc);
        end
        repeat (6) @(negedge clk);
        check("pend_full_ready_low", s_ready, 1'b0);
        push_read(64'h2080, 1'b1);
        issue(1'b0, 64'h2080, '0, 32'hFFFF_FFFF, acc5);
        check("fifth_accept_after_valid", acc5 - first_valid_cyc, 1);
        for (int n = 0; n < 400 && (exp_wide.size() > 0 || resp_q.size() > 0); n++) @(negedge clk);

        // Sparse byteenable
        push_write(64'h4000, WD1, 32'h0000_FF00);
        issue(1'b1, 64'h4000, WD1, 32'h0000_FF00, acc);
        wait_ready(rc);

        // Reset in the middle of gathering a read
        auto_resp = 1'b0;
        push_read(64'h5000, 1'b0);
        issue(1'b0, 64'h5000, '0, 32'hFFFF_FFFF, acc);
        wait_ready(rc);
        @(posedge clk); #1;
        man_valid = 1'b1; man_data = 64'hDEAD_0000_0000_0001;
        @(posedge clk); #1;
        man_data = 64'hDEAD_0000_0000_0002;
        @(posedge clk); #1;
        man_valid = 1'b0;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1; reset = 1'b0;
        p0 = n_pulses;
        @(negedge clk);
        check("ready_after_midreset", s_ready, 1'b1);
        check("req_after_midreset", {m_rd, m_wr, s_valid}, 3'b000);
        @(posedge clk); #1;
        man_valid = 1'b1; man_data = 64'hBAD0_0000_0000_0001;
        @(posedge clk); #1;
        man_data = 64'hBAD0_0000_0000_0002;
        @(posedge clk); #1;
        man_valid = 1'b0;
        repeat (6) @(negedge clk);
        check("no_pulse_from_stray", n_pulses - p0, 0);

        // Unaligned read after reset: low address bits ignored, gather realigned
        auto_resp = 1'b1;
        resp_delay = 3;
        push_read(64'h3007, 1'b1);
        issue(1'b0, 64'h3007, '0, 32'hFFFF_FFFF, acc);
        for (int n = 0; n < 100 && exp_wide.size() > 0; n++) @(negedge clk);

        // Address wrap at the top of the space
        push_write(64'hFFFF_FFFF_FFFF_FFE0, WD2, 32'hFFFF_FFFF);
        issue(1'b1, 64'hFFFF_FFFF_FFFF_FFE0, WD2, 32'hFFFF_FFFF, acc);
        wait_ready(rc);

        repeat (5) @(negedge clk);
        check("beats_left", exp_beats.size(), 0);
        check("wides_left", exp_wide.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
